// File: rtl/eth_tx_sched_pkg.sv
// rtl/eth_tx_sched_pkg.sv - shared types and constants for the Ethernet transmit scheduler
package eth_tx_sched_pkg;

  // Scheduler states; encodings are fixed so they read the same in every dump.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Standard Ethernet inter-frame gap in byte clocks.
  localparam int DEFAULT_IFG = 12;

  // Wraps an index that has been advanced by less than n back into 0..n-1.
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/eth_tx_sched_rr_arbiter.sv
// rtl/eth_tx_sched_rr_arbiter.sv - combinational round-robin pick among N requesters
//
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  highest-priority index for this pick
//   gnt  out N   one-hot grant, zero when nothing requests
//   idx  out IW  index of the granted requester, zero when nothing requests
module rr_arbiter
  import eth_tx_sched_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk the requesters starting at ptr and wrapping; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'(wrap_idx(int'(ptr) + k, N));
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin scheduler sharing one frame transmitter between N sources
//
// Ports:
//   clk, rst            byte clock; asynchronous active-high reset
//   src_req / src_ack   per-source level request, one-cycle completion pulse
//   src_fs / src_fd     payload start to / payload done from the granted source
//   src_txd             payload bytes, source i on [8i+7:8i]
//   tx_rdy / tx_fs      transmitter idle indication / level frame start
//   tx_fd               level frame done from the transmitter
//   mac_fs / mac_fd     payload handshake from / to the transmitter
//   mac_txd             payload byte to the transmitter
//   gnt_idx             current or last granted source
//   busy                low only while arbitrating
//   frame_cnt           completed frames, wrapping
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int N   = 3,
  parameter int IW  = $clog2(N),
  parameter int IFG = DEFAULT_IFG
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   src_req,
  output logic [N-1:0]   src_ack,
  output logic [N-1:0]   src_fs,
  input  logic [N-1:0]   src_fd,
  input  logic [8*N-1:0] src_txd,
  input  logic           tx_rdy,
  output logic           tx_fs,
  input  logic           tx_fd,
  input  logic           mac_fs,
  output logic           mac_fd,
  output logic [7:0]     mac_txd,
  output logic [IW-1:0]  gnt_idx,
  output logic           busy,
  output logic [15:0]    frame_cnt
);

  // The first GAP cycle already counts, so the counter starts one below IFG.
  localparam logic [15:0] IFG_LOAD = (IFG > 0) ? 16'(IFG - 1) : 16'd0;

  state_t        state_q, state_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]  gnt_oh_q, gnt_oh_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]  ack_q, ack_d;
  logic          tx_fs_q, tx_fs_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   gap_q, gap_d;

  logic [N-1:0]  arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          in_send;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req (src_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    rr_ptr_d    = rr_ptr_q;
    ack_d       = '0;
    tx_fs_d     = tx_fs_q;
    frame_cnt_d = frame_cnt_q;
    gap_d       = gap_q;
    case (state_q)
      ST_IDLE: state_d = ST_ARB;
      ST_ARB: begin
        if (tx_rdy && (|src_req)) begin
          state_d   = ST_SEND;
          gnt_idx_d = arb_idx;
          gnt_oh_d  = arb_gnt;
          tx_fs_d   = 1'b1;
        end
      end
      ST_SEND: begin
        // A done level already present on entry is taken as completion.
        if (tx_fd) begin
          state_d     = ST_DONE;
          tx_fs_d     = 1'b0;
          ack_d       = gnt_oh_q;
          rr_ptr_d    = IW'(wrap_idx(int'(gnt_idx_q) + 1, N));
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        // Hold tx_fs low until the transmitter has dropped its done level.
        if (!tx_fd) begin
          if (IFG == 0) begin
            state_d = ST_ARB;
          end else begin
            state_d = ST_GAP;
            gap_d   = IFG_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 16'd0) begin
          state_d = ST_ARB;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      tx_fs_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      gap_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      tx_fs_q     <= tx_fs_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
    end
  end

  // Payload path is a pure mux on the registered grant, open only in SEND.
  assign in_send   = (state_q == ST_SEND);
  assign src_fs    = in_send ? ({N{mac_fs}} & gnt_oh_q) : '0;
  assign mac_fd    = in_send & src_fd[gnt_idx_q];
  assign mac_txd   = in_send ? src_txd[{gnt_idx_q, 3'b000} +: 8] : 8'h00;

  assign src_ack   = ack_q;
  assign tx_fs     = tx_fs_q;
  assign gnt_idx   = gnt_idx_q;
  assign busy      = (state_q != ST_ARB);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - self-checking bench for eth_tx_sched
module tb_eth_tx_sched;
  localparam int N   = 3;
  localparam int IW  = 2;
  localparam int IFG = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   src_req = '0;
  logic [N-1:0]   src_fd = '0;
  logic [8*N-1:0] src_txd = '0;
  logic           tx_rdy = 1'b0;
  logic           tx_fd = 1'b0;
  logic           mac_fs = 1'b0;
  logic [N-1:0]   src_ack, src_fs;
  logic           tx_fs, mac_fd, busy;
  logic [7:0]     mac_txd;
  logic [IW-1:0]  gnt_idx;
  logic [15:0]    frame_cnt;

  // Second instance with no inter-frame gap, driven by its own tiny transmitter.
  logic [N-1:0]   src_req0 = 3'b001;
  logic           tx_fd0 = 1'b0;
  logic [N-1:0]   src_ack0, src_fs0;
  logic           tx_fs0, mac_fd0, busy0;
  logic [7:0]     mac_txd0;
  logic [IW-1:0]  gnt_idx0;
  logic [15:0]    frame_cnt0;

  int n_cmp = 0;
  int n_bad = 0;
  int flen = 4;
  int cyc = 0;
  logic [15:0] preset_val = 16'd0;
  logic        preset_tog = 1'b0;

  eth_tx_sched #(.N(N), .IW(IW), .IFG(IFG)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_ack(src_ack), .src_fs(src_fs),
    .src_fd(src_fd), .src_txd(src_txd), .tx_rdy(tx_rdy), .tx_fs(tx_fs), .tx_fd(tx_fd),
    .mac_fs(mac_fs), .mac_fd(mac_fd), .mac_txd(mac_txd), .gnt_idx(gnt_idx),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  eth_tx_sched #(.N(N), .IW(IW), .IFG(0)) dut0 (
    .clk(clk), .rst(rst), .src_req(src_req0), .src_ack(src_ack0), .src_fs(src_fs0),
    .src_fd(3'b000), .src_txd(24'h0), .tx_rdy(1'b1), .tx_fs(tx_fs0), .tx_fd(tx_fd0),
    .mac_fs(1'b0), .mac_fd(mac_fd0), .mac_txd(mac_txd0), .gnt_idx(gnt_idx0),
    .busy(busy0), .frame_cnt(frame_cnt0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Transmitter and source emulation: frames last flen cycles, data changes each cycle.
  initial begin
    int fl;
    fl = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!tx_fs) begin
        tx_fd = 1'b0;
        fl = 0;
      end else begin
        fl++;
        tx_fd = (fl >= flen);
      end
      mac_fs = tx_fs && !tx_fd;
      for (int i = 0; i < N; i++) src_txd[8*i +: 8] = 8'(i * 64 + (cyc % 64));
      src_fd = 3'(cyc % 8);
    end
  end

  // One-cycle done pulse for the IFG=0 instance.
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_fd0 = tx_fs0 && !tx_fd0;
    end
  end

  // IFG=0: frame start must come back exactly 2 cycles after it fell.
  initial begin
    int t, fall, gaps;
    logic prev;
    t = 0; fall = -1; gaps = 0; prev = 1'b0;
    @(negedge rst);
    repeat (80) begin
      @(negedge clk);
      t++;
      if (prev && !tx_fs0) fall = t;
      if (!prev && tx_fs0 && fall >= 0 && gaps < 2) begin
        chk("ifg0_gap", t - fall, 2);
        gaps++;
      end
      prev = tx_fs0;
    end
    chk("ifg0_frames", gaps, 2);
  end

  // Timeline model: frame windows, grant choice, acks and count, checked every cycle.
  initial begin
    logic        in_frame, done_wait, seen_tog;
    int          arb_from, ptr, gnt, n;
    logic [15:0] cnt;
    logic [N-1:0] ack, exp_fs;
    logic        exp_busy;
    in_frame = 0; done_wait = 0; seen_tog = 0;
    arb_from = 0; ptr = 0; gnt = 0; n = 0; cnt = 0; ack = 0;
    forever begin
      @(negedge clk);
      n++;
      if (preset_tog != seen_tog) begin
        seen_tog = preset_tog;
        cnt = preset_val;
      end
      if (rst) begin
        in_frame = 0; done_wait = 0; ptr = 0; gnt = 0; cnt = 0; ack = 0;
        arb_from = n + 2;
      end
      exp_busy = !(!in_frame && !done_wait && n >= arb_from);
      exp_fs   = (in_frame && mac_fs) ? N'(1 << gnt) : '0;
      chk("m_tx_fs", tx_fs, in_frame);
      chk("m_busy", busy, exp_busy);
      chk("m_src_ack", src_ack, ack);
      chk("m_frame_cnt", frame_cnt, cnt);
      chk("m_gnt_idx", gnt_idx, gnt);
      chk("m_src_fs", src_fs, exp_fs);
      chk("m_mac_fd", mac_fd, in_frame ? src_fd[gnt] : 1'b0);
      chk("m_mac_txd", mac_txd, in_frame ? src_txd[8*gnt +: 8] : 8'h00);
      ack = '0;
      if (!rst) begin
        if (in_frame) begin
          if (tx_fd) begin
            in_frame = 0; done_wait = 1;
            ack = N'(1 << gnt);
            cnt = cnt + 16'd1;
            ptr = (gnt + 1) % N;
          end
        end else if (done_wait) begin
          if (!tx_fd) begin
            done_wait = 0;
            arb_from = n + 1 + IFG;
          end
        end else if (n >= arb_from && tx_rdy && (|src_req)) begin
          gnt = rr_pick(src_req, ptr);
          in_frame = 1;
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_fs(input logic v, input int maxc, output int c);
    c = 0;
    while (tx_fs !== v && c < maxc) begin
      step(1);
      c++;
    end
    chk("wait_tx_fs", tx_fs, v);
  endtask

  task automatic wait_ack(input string name, input logic [N-1:0] expv, input int maxc);
    int c;
    c = 0;
    while (src_ack == '0 && c < maxc) begin
      step(1);
      c++;
    end
    chk(name, src_ack, expv);
  endtask

  initial begin
    int c;
    int rr_exp[5];
    rr_exp = '{0, 1, 2, 0, 1};

    step(3);
    chk("rst_tx_fs", tx_fs, 0);
    chk("rst_busy", busy, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_gnt_idx", gnt_idx, 0);
    chk("rst_src_ack", src_ack, 0);
    rst = 1'b0;

    // Round robin with all sources requesting; every gap must be IFG+2 = 14.
    tx_rdy = 1'b1;
    src_req = 3'b111;
    for (int f = 0; f < 5; f++) begin
      wait_fs(1'b1, 60, c);
      if (f > 0) chk("ifg_gap", c, 14);
      chk("rr_gnt", gnt_idx, rr_exp[f]);
      wait_fs(1'b0, 20, c);
    end

    // Single source 1; pointer now sits at 2.
    src_req = 3'b010;
    wait_fs(1'b1, 40, c);
    chk("single_gnt", gnt_idx, 1);
    chk("single_txd", mac_txd, src_txd[15:8]);
    wait_ack("single_ack", 3'b010, 20);
    chk("single_cnt", frame_cnt, 6);
    src_req = 3'b000;

    // tx_rdy gating: no start while low, start the cycle after it rises.
    tx_rdy = 1'b0;
    step(30);
    src_req = 3'b001;
    c = 0;
    repeat (20) begin
      step(1);
      if (tx_fs) c++;
    end
    chk("rdy_gate_hi", c, 0);
    tx_rdy = 1'b1;
    step(1);
    chk("rdy_grant", tx_fs, 1);
    chk("rdy_gnt", gnt_idx, 0);
    src_req = 3'b000;
    wait_ack("rdy_ack", 3'b001, 20);

    // Request dropped mid-frame: frame still completes and is acked.
    src_req = 3'b100;
    wait_fs(1'b1, 40, c);
    chk("drop_gnt", gnt_idx, 2);
    step(1);
    src_req = 3'b000;
    wait_ack("drop_ack", 3'b100, 20);
    chk("drop_cnt", frame_cnt, 8);

    // Counter wrap: preset to FFFF while in the gap, then one more frame.
    step(3);
    force dut.frame_cnt_q = 16'hFFFF;
    preset_val = 16'hFFFF;
    preset_tog = ~preset_tog;
    step(1);
    release dut.frame_cnt_q;
    src_req = 3'b001;
    wait_ack("wrap_ack", 3'b001, 60);
    chk("wrap_cnt", frame_cnt, 0);
    src_req = 3'b000;

    // Reset in the middle of a frame.
    step(20);
    src_req = 3'b001;
    wait_fs(1'b1, 40, c);
    step(1);
    chk("pre_rst_src_fs", src_fs, 3'b001);
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_fs", tx_fs, 0);
    chk("rst_mid_src_fs", src_fs, 0);
    chk("rst_mid_mac_fd", mac_fd, 0);
    chk("rst_mid_busy", busy, 1);
    step(1);
    rst = 1'b0;
    wait_fs(1'b1, 10, c);
    chk("rst_recover", c, 2);
    chk("rst_recover_gnt", gnt_idx, 0);
    chk("rst_recover_cnt", frame_cnt, 0);
    src_req = 3'b000;
    wait_ack("rst_recover_ack", 3'b001, 20);
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Transmit scheduler that shares the single Ethernet frame transmitter between N packet sources, for example ARP reply, ICMP and UDP data. It picks one requesting source round-robin and starts the transmitter with a level fs/fd handshake. While the frame is in flight it routes the transmitter's payload handshake and byte stream to and from the granted source. After each frame it enforces a programmable inter-frame gap before the next arbitration.

## Interface
Parameters:
- N, 3: number of sources, at least 2.
- IW, $clog2(N): index width.
- IFG, 12: idle cycles between frames; 0 is legal.

Ports:
- clk  in  1  byte clock.
- rst  in  1  reset, asynchronous, active-high.
- src_req  in  N  per-source frame request, level; held until src_ack.
- src_ack  out  N  one-cycle pulse to the granted source when its frame completes.
- src_fs  out  N  payload start to the granted source.
- src_fd  in  N  payload done from each source.
- src_txd  in  8N  payload bytes; source i drives [8i+7:8i].
- tx_rdy  in  1  transmitter idle and ready to accept a frame start.
- tx_fs  out  1  frame start to the transmitter, level.
- tx_fd  in  1  frame done from the transmitter, level.
- mac_fs  in  1  payload start request from the transmitter.
- mac_fd  out  1  payload done to the transmitter.
- mac_txd  out  8  payload byte to the transmitter.
- gnt_idx  out  IW  index of the current or last granted source.
- busy  out  1  high in every state except ARB.
- frame_cnt  out  16  count of completed frames, all sources; wraps.

## Operation
States: IDLE, ARB, SEND, DONE, GAP.
- IDLE: the state after reset. Goes to ARB on the next cycle.
- ARB: if tx_rdy and |src_req, go to SEND. gnt_idx is registered with the first requester at or above rr_ptr, searching cyclically.
- SEND: tx_fs=1, registered. Stays in SEND until tx_fd=1, then goes to DONE. On that transition:
  - src_ack[gnt_idx] is registered high for exactly one cycle.
  - rr_ptr becomes gnt_idx+1, wrapping from N-1 to 0.
  - frame_cnt increments.
- DONE: tx_fs=0. Waits for tx_fd=0. Then goes to GAP with the counter loaded to IFG-1, or goes straight to ARB when IFG=0.
- GAP: the counter decrements each cycle. When it reaches 0, go to ARB.

Combinational routing, active only in SEND, all zero otherwise:
- src_fs[i] = mac_fs & (i==gnt_idx).
- mac_fd = src_fd[gnt_idx].
- mac_txd = src_txd[gnt_idx].

Boundary conditions:
- A source that drops src_req during SEND does not abort the frame. The frame completes and is acked normally.
- src_req changes outside ARB are ignored.
- A source that keeps src_req high after its ack competes again. It has lowest priority in the next arbitration.
- tx_rdy=0 in ARB: remain in ARB with no grant.
- tx_fd already high on entry to SEND is accepted as done. The transmitter guarantees tx_fd=0 when it accepts tx_fs.
- Reset mid-frame: all state clears immediately. tx_fs drops, which aborts the transmitter handshake.
- Reset values: tx_fs=0, src_ack=0, src_fs=0, mac_fd=0, mac_txd=0, gnt_idx=0, rr_ptr=0, busy=1 (IDLE), frame_cnt=0, GAP counter 0.

## Timing
- Grant latency: request seen in ARB at cycle t gives tx_fs=1 and a valid gnt_idx at t+1.
- tx_fd=1 at cycle t gives tx_fs=0 and src_ack pulse at t+1.
- Frame-to-frame: DONE lasts at least 1 cycle, plus IFG cycles in GAP, plus 1 cycle in ARB. The next tx_fs rises no earlier than IFG+2 cycles after tx_fs falls.
- Payload path: zero-latency combinational, both ways.
- The one-cycle tx_fs low time in DONE is guaranteed; the transmitter needs it to return to idle.

## Structure
- Shared package: state encodings (IDLE 0 .. GAP 4, 3 bits) and the default IFG constant.
- Sub-module rr_arbiter: pure combinational. Inputs req[N] and ptr[IW]; outputs a one-hot grant and the granted index. Instantiated once and used in ARB only.

## Test plan
- Single source: N=3, src_req=3'b010, tx_rdy=1. Expect:
  - tx_fs rises the cycle after ARB, with gnt_idx=1.
  - mac_txd tracks src_txd[15:8].
  - The tx_fd pulse gives src_ack=3'b010 for 1 cycle.
  - frame_cnt=1.
- Round-robin: src_req=3'b111 held, with each frame acked. Expect the grant order 0,1,2,0.
- IFG: IFG=12. Expect exactly 14 cycles between the tx_fs fall and the next tx_fs rise with a request pending; with IFG=0, 2 cycles.
- tx_rdy gating: request pending, tx_rdy=0 for 20 cycles. Expect tx_fs=0 throughout and the grant on the cycle after tx_rdy rises.
- Mid-frame events:
  - Request drop: src_req[2] drops during SEND; the frame still completes and src_ack[2] pulses.
  - Reset: rst asserted in SEND; tx_fs, src_fs and mac_fd go to 0 immediately, and the block returns to IDLE and then ARB.
- frame_cnt wrap: preload near 16'hFFFF via 65536 short frames, or force the counter. Expect a wrap to 0.
